// File: rtl/multicycle_exec_sched_pkg.sv
// Shared types and constants for the EX-stage multi-cycle scheduler.
// Build option: EXEC_TIMEOUT_EN enables the wait watchdog.
package multicycle_exec_sched_pkg;

    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    localparam int ITYPE_W         = 13;
    localparam int ITYPE_DIVREM    = 7;
    localparam int ITYPE_FAISFLOAT = 10;
    localparam int ITYPE_FAISINT   = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DIV = 3'd1,
        ST_WAIT_FP  = 3'd2,
        ST_DONE     = 3'd3,
        ST_DRAIN    = 3'd4
    } sched_state_e;

    typedef enum logic {
        UNIT_DIV = 1'b0,
        UNIT_FP  = 1'b1
    } unit_e;

    function automatic logic is_wait(input sched_state_e s);
        return (s == ST_WAIT_DIV) || (s == ST_WAIT_FP);
    endfunction

endpackage

// File: rtl/multicycle_exec_sched_if.sv
// Pipeline/unit-facing signal bundle of the scheduler; slave = scheduler side.
// oTimeout exists only when EXEC_TIMEOUT_EN is defined.
interface multicycle_exec_sched_if
    import multicycle_exec_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                iValid;
    logic [ITYPE_W-1:0]  iInstrType;
    logic                iFlush;
    logic                iDivReady;
    logic [DATA_W-1:0]   iDivResult;
    logic                iFPALUReady;
    logic [DATA_W-1:0]   iFPResult;
    logic                oDivStart;
    logic                oFPALUStart;
    logic                oStall;
    logic                oResultValid;
    logic [DATA_W-1:0]   oResult;
    logic [1:0]          oBusy;
`ifdef EXEC_TIMEOUT_EN
    logic                oTimeout;
`endif

    modport slave (
        input  iValid, iInstrType, iFlush, iDivReady, iDivResult, iFPALUReady, iFPResult,
        output oDivStart, oFPALUStart, oStall, oResultValid, oResult, oBusy
`ifdef EXEC_TIMEOUT_EN
        , output oTimeout
`endif
    );

    modport master (
        output iValid, iInstrType, iFlush, iDivReady, iDivResult, iFPALUReady, iFPResult,
        input  oDivStart, oFPALUStart, oStall, oResultValid, oResult, oBusy
`ifdef EXEC_TIMEOUT_EN
        , input oTimeout
`endif
    );

endinterface

// File: rtl/multicycle_exec_sched_wait_timer.sv
// Watchdog for the scheduler wait states; expired_o is high while counting at TIMEOUT_CYCLES-1.
// Only instantiated when EXEC_TIMEOUT_EN is defined.
module exec_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_exec_sched.sv
// EX-stage scheduler for the DivRem unit and FP ALU: start pulse, stall, capture, flush drain.
// Build option: EXEC_TIMEOUT_EN adds a wait watchdog (exec_wait_timer) and the oTimeout pulse.
module multicycle_exec_sched
    import multicycle_exec_sched_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    multicycle_exec_sched_if.slave  bus
);

    sched_state_e      state_q, state_d;
    unit_e             unit_q, unit_d;
    logic              div_start_q, div_start_d;
    logic              fp_start_q, fp_start_d;
    logic [DATA_W-1:0] result_q, result_d;
`ifdef EXEC_TIMEOUT_EN
    logic              timeout_q, timeout_d;
`endif

    logic              div_req, fp_req, any_req;
    logic              accept, waiting, draining;
    logic              unit_rdy;
    logic [DATA_W-1:0] unit_res;
    logic              wait_expired;

    assign div_req  = bus.iValid & bus.iInstrType[ITYPE_DIVREM];
    assign fp_req   = bus.iValid & (bus.iInstrType[ITYPE_FAISFLOAT] | bus.iInstrType[ITYPE_FAISINT]);
    assign any_req  = div_req | fp_req;
    assign waiting  = is_wait(state_q);
    assign draining = (state_q == ST_DRAIN);
    assign accept   = (state_q == ST_IDLE) && any_req && !bus.iFlush;

    // A ready seen while our own start pulse is still high belongs to a previous op.
    assign unit_rdy = (unit_q == UNIT_FP) ? (bus.iFPALUReady & ~fp_start_q)
                                          : (bus.iDivReady & ~div_start_q);
    assign unit_res = (unit_q == UNIT_FP) ? bus.iFPResult : bus.iDivResult;

`ifdef EXEC_TIMEOUT_EN
    exec_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .clr_i     (accept),
        .en_i      (waiting | draining),
        .expired_o (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        result_d    = result_q;
        div_start_d = 1'b0;
        fp_start_d  = 1'b0;
`ifdef EXEC_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (div_req && !bus.iFlush) begin
                    state_d     = ST_WAIT_DIV;
                    unit_d      = UNIT_DIV;
                    div_start_d = 1'b1;
                end else if (fp_req && !bus.iFlush) begin
                    state_d    = ST_WAIT_FP;
                    unit_d     = UNIT_FP;
                    fp_start_d = 1'b1;
                end
            end
            ST_WAIT_DIV, ST_WAIT_FP: begin
                // Flush beats a same-cycle ready; the result is dropped either way.
                if (bus.iFlush) begin
                    state_d = unit_rdy ? ST_IDLE : ST_DRAIN;
                end else if (unit_rdy) begin
                    result_d = unit_res;
                    state_d  = ST_DONE;
                end else if (wait_expired) begin
                    result_d = '0;
                    state_d  = ST_DONE;
`ifdef EXEC_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (unit_rdy || wait_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            unit_q      <= UNIT_DIV;
            div_start_q <= 1'b0;
            fp_start_q  <= 1'b0;
            result_q    <= '0;
`ifdef EXEC_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            div_start_q <= div_start_d;
            fp_start_q  <= fp_start_d;
            result_q    <= result_d;
`ifdef EXEC_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.oDivStart    = div_start_q;
    assign bus.oFPALUStart  = fp_start_q;
    assign bus.oResult      = result_q;
    assign bus.oResultValid = (state_q == ST_DONE) && !bus.iFlush;
    assign bus.oStall       = ((state_q == ST_IDLE) && any_req && !bus.iFlush)
                            | waiting
                            | (draining && any_req);
    assign bus.oBusy        = {(state_q == ST_WAIT_FP)  | (draining && (unit_q == UNIT_FP)),
                               (state_q == ST_WAIT_DIV) | (draining && (unit_q == UNIT_DIV))};
`ifdef EXEC_TIMEOUT_EN
    assign bus.oTimeout     = timeout_q;
`endif

    logic unused_itype;
    assign unused_itype = ^{bus.iInstrType[12], bus.iInstrType[9:8], bus.iInstrType[6:0]};

    a_req_exclusive: assert property (@(posedge iCLK) disable iff (iRST) !(div_req && fp_req));
    a_timeout_range: assert property (@(posedge iCLK) (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 256));

endmodule

// File: tb/tb_multicycle_exec_sched.sv
// Directed bench for multicycle_exec_sched; inputs change 1ns after posedge, outputs sampled at negedge.
// Timeout scenario is compiled in only with EXEC_TIMEOUT_EN (bench uses TIMEOUT_CYCLES=8).
module tb_multicycle_exec_sched;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    localparam logic [12:0] T_DIV  = 13'b0000010010000;
    localparam logic [12:0] T_FP   = 13'b0010000000000;
    localparam logic [31:0] FP_VAL = 32'h3F80_0000;

    multicycle_exec_sched_if #(.DATA_W(32)) bus ();

    multicycle_exec_sched #(
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {oDivStart, oFPALUStart, oStall, oResultValid, oBusy}
    function automatic logic [5:0] obs();
        return {bus.oDivStart, bus.oFPALUStart, bus.oStall, bus.oResultValid, bus.oBusy};
    endfunction

    task automatic drive(input logic v, input logic [12:0] ty, input logic fl,
                         input logic dr, input logic [31:0] dres,
                         input logic fr, input logic [31:0] fres);
        bus.iValid      = v;
        bus.iInstrType  = ty;
        bus.iFlush      = fl;
        bus.iDivReady   = dr;
        bus.iDivResult  = dres;
        bus.iFPALUReady = fr;
        bus.iFPResult   = fres;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs() !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), 6'b0);
        end
        checks++;
        if (bus.oResult !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=%h", bus.oResult, 32'h0);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_div();
        logic [5:0] exp;
        for (int t = 0; t < 8; t++) begin
            drive(t <= 6, (t <= 6) ? T_DIV : 13'h0, 1'b0, t == 5,
                  (t == 5) ? 32'h0000_0007 : 32'hBAD0_0000, 1'b0, 32'h0);
            exp = {t == 1, 1'b0, t <= 5, t == 6, (t >= 1 && t <= 5) ? 2'b01 : 2'b00};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL div t=%0d got=%b exp=%b", t, obs(), exp);
            end
            if (t == 6) begin
                checks++;
                if (bus.oResult !== 32'h0000_0007) begin
                    failures++;
                    $display("FAIL div_result got=%h exp=%h", bus.oResult, 32'h7);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fp();
        logic [5:0] exp;
        for (int t = 0; t < 6; t++) begin
            drive(t <= 4, (t <= 4) ? T_FP : 13'h0, 1'b0, 1'b0, 32'h0,
                  (t == 1) || (t == 3), (t == 3) ? FP_VAL : 32'hDEAD_BEEF);
            exp = {1'b0, t == 1, t <= 3, t == 4, (t >= 1 && t <= 3) ? 2'b10 : 2'b00};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL fp t=%0d got=%b exp=%b", t, obs(), exp);
            end
            if (t == 4) begin
                checks++;
                if (bus.oResult !== FP_VAL) begin
                    failures++;
                    $display("FAIL fp_result got=%h exp=%h", bus.oResult, FP_VAL);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        logic [5:0] exp;
        for (int t = 0; t < 9; t++) begin
            drive(t <= 2, (t <= 2) ? T_DIV : 13'h0, t == 2, t == 6,
                  (t == 6) ? 32'h0000_0055 : 32'h0, 1'b0, 32'h0);
            exp = {t == 1, 1'b0, t <= 2, 1'b0, (t >= 1 && t <= 6) ? 2'b01 : 2'b00};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL flush t=%0d got=%b exp=%b", t, obs(), exp);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (bus.oResult !== FP_VAL) begin
            failures++;
            $display("FAIL flush_result_hold got=%h exp=%h", bus.oResult, FP_VAL);
        end
        next_cycle();
    endtask

    task automatic test_flush_edges();
        logic [5:0] exp;
        // flush together with ready in WAIT: straight to IDLE, nothing captured
        for (int t = 0; t < 4; t++) begin
            drive(t <= 2, (t <= 2) ? T_DIV : 13'h0, t == 2, t == 2,
                  32'h0000_0099, 1'b0, 32'h0);
            exp = {t == 1, 1'b0, t <= 2, 1'b0, (t >= 1 && t <= 2) ? 2'b01 : 2'b00};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL flush_rdy t=%0d got=%b exp=%b", t, obs(), exp);
            end
            next_cycle();
        end
        // minimum latency capture, then flush in DONE suppresses valid only
        for (int t = 0; t < 5; t++) begin
            drive(t <= 3, (t <= 3) ? T_DIV : 13'h0, t == 3, t == 2,
                  32'h0000_00AA, 1'b0, 32'h0);
            exp = {t == 1, 1'b0, t <= 2, 1'b0, (t >= 1 && t <= 2) ? 2'b01 : 2'b00};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL done_flush t=%0d got=%b exp=%b", t, obs(), exp);
            end
            if (t == 3) begin
                checks++;
                if (bus.oResult !== 32'h0000_00AA) begin
                    failures++;
                    $display("FAIL done_flush_result got=%h exp=%h", bus.oResult, 32'hAA);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        logic [1:0] eb;
        for (int t = 0; t < 12; t++) begin
            drive(t <= 10, (t <= 2) ? T_DIV : ((t <= 10) ? T_FP : 13'h0), t == 2,
                  t == 5, 32'h0, t == 9, (t == 9) ? FP_VAL : 32'h0);
            if (t >= 1 && t <= 5)      eb = 2'b01;
            else if (t >= 7 && t <= 9) eb = 2'b10;
            else                       eb = 2'b00;
            exp = {t == 1, t == 7, t <= 9, t == 10, eb};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL b2b t=%0d got=%b exp=%b", t, obs(), exp);
            end
            if (t == 10) begin
                checks++;
                if (bus.oResult !== FP_VAL) begin
                    failures++;
                    $display("FAIL b2b_result got=%h exp=%h", bus.oResult, FP_VAL);
                end
            end
            next_cycle();
        end
    endtask

`ifdef EXEC_TIMEOUT_EN
    task automatic test_timeout();
        logic [5:0] exp;
        for (int t = 0; t < 11; t++) begin
            drive(t <= 9, (t <= 9) ? T_DIV : 13'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            exp = {t == 1, 1'b0, t <= 8, t == 9, (t >= 1 && t <= 8) ? 2'b01 : 2'b00};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL timeout t=%0d got=%b exp=%b", t, obs(), exp);
            end
            checks++;
            if (bus.oTimeout !== (t == 9)) begin
                failures++;
                $display("FAIL timeout_pulse t=%0d got=%b exp=%b", t, bus.oTimeout, t == 9);
            end
            if (t == 9) begin
                checks++;
                if (bus.oResult !== 32'h0) begin
                    failures++;
                    $display("FAIL timeout_result got=%h exp=%h", bus.oResult, 32'h0);
                end
            end
            next_cycle();
        end
        next_cycle();
    endtask
`endif

    task automatic test_reset_mid_wait();
        for (int t = 0; t < 8; t++) begin
            drive(t <= 2, (t <= 2) ? T_FP : 13'h0, 1'b0, 1'b0, 32'h0,
                  t == 5, 32'h1234_5678);
            rst = (t == 3);
            @(negedge clk);
            if (t == 2) begin
                checks++;
                if (obs() !== 6'b001010) begin
                    failures++;
                    $display("FAIL rst_wait_pre got=%b exp=%b", obs(), 6'b001010);
                end
            end
            if (t >= 4) begin
                checks++;
                if (obs() !== 6'b0 || bus.oResult !== 32'h0) begin
                    failures++;
                    $display("FAIL rst_wait t=%0d got=%b/%h exp=%b/%h", t, obs(), bus.oResult,
                             6'b0, 32'h0);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        test_reset();
        test_div();
        test_fp();
        test_flush();
        test_flush_edges();
        test_back_to_back();
`ifdef EXEC_TIMEOUT_EN
        test_timeout();
        test_fp();
`endif
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
